// File: rtl/ysyx_2022040010_ifetch_resp.sv
// ysyx_2022040010_ifetch_resp: instruction fetch responder with optional 8-byte line buffer (YSYX_2022040010_IFETCH_LINEBUF_EN)
module ysyx_2022040010_ifetch_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        isram_e,
  input  logic [63:0] isram_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic        stall_req,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state, state_n;
  logic [63:0] req_addr;
  logic hit, ack, hit_req, miss_req, unused_ok;
  logic [31:0] hit_inst;
  assign ack = state == FETCH && mem_ack;
  assign hit_req = state == IDLE && isram_e && hit;
  assign miss_req = state == IDLE && isram_e && !hit;
  assign unused_ok = ^{isram_addr[1:0], req_addr[1:0]};
`ifdef YSYX_2022040010_IFETCH_LINEBUF_EN
  logic buf_valid;
  logic [60:0] buf_tag;
  logic [63:0] buf_data;
  assign hit = buf_valid && buf_tag == isram_addr[63:3];
  assign hit_inst = isram_addr[2] ? buf_data[63:32] : buf_data[31:0];
  // an errored fill invalidates the line but leaves the old data in place
  always_ff @(posedge clk)
    if (rst) buf_valid <= 1'b0;
    else if (ack) begin
      buf_valid <= !mem_err;
      if (!mem_err) begin
        buf_tag <= req_addr[63:3];
        buf_data <= mem_rdata;
      end
    end
`else
  assign hit = 1'b0;
  assign hit_inst = 32'h0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (miss_req ? FETCH : IDLE) :
              state == FETCH ? (mem_ack ? DONE : FETCH) : IDLE;
    stall_req = miss_req || state == FETCH;
    mem_req = state == FETCH;
    mem_addr = state == FETCH ? {req_addr[63:3], 3'b000} : 64'h0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      req_addr <= 64'h0;
      inst_valid <= 1'b0;
      inst <= 32'h0;
      inst_err <= 1'b0;
    end else begin
      if (miss_req) req_addr <= isram_addr;
      inst_valid <= hit_req || ack;
      inst_err <= ack && mem_err;
      inst <= ack ? (mem_err ? 32'h0 : req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]) :
              hit_req ? hit_inst : 32'h0;
    end
endmodule

// File: tb/tb_ysyx_2022040010_ifetch_resp.sv
// tb_ysyx_2022040010_ifetch_resp: directed self-checking bench for the fetch responder
module tb_ysyx_2022040010_ifetch_resp;
  logic clk = 1'b0, rst = 1'b1, isram_e = 1'b0, mem_ack = 1'b0, mem_err = 1'b0;
  logic [63:0] isram_addr = '0, mem_rdata = '0, mem_addr;
  logic inst_valid, inst_err, stall_req, mem_req;
  logic [31:0] inst;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  ysyx_2022040010_ifetch_resp dut (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr),
    .inst_valid(inst_valid), .inst(inst), .inst_err(inst_err), .stall_req(stall_req),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  // lat = number of FETCH cycles, mem_ack arrives in the last one
  task automatic miss(input logic [63:0] addr, input int lat, input logic [63:0] rdata,
                      input logic err, input logic [31:0] exp_inst);
    isram_e = 1'b1;
    isram_addr = addr;
    #1;
    chk("miss_stall_req_cycle", {63'h0, stall_req}, 64'h1);
    chk("miss_no_mem_req_yet", {63'h0, mem_req}, 64'h0);
    tick;
    isram_e = 1'b1;
    isram_addr = 64'hdead_beef_0000_0010;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("fetch_mem_req", {63'h0, mem_req}, 64'h1);
      chk("fetch_mem_addr", mem_addr, {addr[63:3], 3'b000});
      chk("fetch_stall", {63'h0, stall_req}, 64'h1);
      chk("fetch_no_valid", {63'h0, inst_valid}, 64'h0);
      if (i == lat - 1) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
        mem_err = err;
      end
      tick;
    end
    mem_ack = 1'b0;
    mem_err = 1'b0;
    isram_e = 1'b0;
    #1;
    chk("done_valid", {63'h0, inst_valid}, 64'h1);
    chk("done_inst", {32'h0, inst}, {32'h0, exp_inst});
    chk("done_err", {63'h0, inst_err}, {63'h0, err});
    chk("done_stall", {63'h0, stall_req}, 64'h0);
    chk("done_mem_req", {63'h0, mem_req}, 64'h0);
    tick;
    chk("after_done_valid", {63'h0, inst_valid}, 64'h0);
  endtask
  task automatic hit(input logic [63:0] addr, input logic [31:0] exp_inst);
    isram_e = 1'b1;
    isram_addr = addr;
    #1;
    chk("hit_stall", {63'h0, stall_req}, 64'h0);
    chk("hit_mem_req", {63'h0, mem_req}, 64'h0);
    tick;
    isram_e = 1'b0;
    #1;
    chk("hit_valid", {63'h0, inst_valid}, 64'h1);
    chk("hit_inst", {32'h0, inst}, {32'h0, exp_inst});
    chk("hit_err", {63'h0, inst_err}, 64'h0);
    chk("hit_mem_req_after", {63'h0, mem_req}, 64'h0);
    tick;
    chk("after_hit_valid", {63'h0, inst_valid}, 64'h0);
  endtask
  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_err", {63'h0, inst_err}, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_stall", {63'h0, stall_req}, 64'h0);
    miss(64'h8000_0000, 3, 64'h0000_0013_0010_0093, 1'b0, 32'h0010_0093);
`ifdef YSYX_2022040010_IFETCH_LINEBUF_EN
    hit(64'h8000_0004, 32'h0000_0013);
`else
    miss(64'h8000_0004, 1, 64'h0000_0013_0010_0093, 1'b0, 32'h0000_0013);
`endif
    miss(64'h8000_0008, 2, 64'h5555_6666_7777_8888, 1'b1, 32'h0);
    miss(64'h8000_000C, 1, 64'h1111_2222_3333_4444, 1'b0, 32'h1111_2222);
`ifdef YSYX_2022040010_IFETCH_LINEBUF_EN
    hit(64'h8000_0008, 32'h3333_4444);
`endif
    isram_e = 1'b1;
    isram_addr = 64'h9000_0000;
    tick;
    isram_e = 1'b0;
    #1;
    chk("rstmid_mem_req_before", {63'h0, mem_req}, 64'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 64'hffff_ffff_ffff_ffff;
    #1;
    chk("rstmid_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rstmid_stall", {63'h0, stall_req}, 64'h0);
    chk("rstmid_mem_addr", mem_addr, 64'h0);
    tick;
    mem_ack = 1'b0;
    chk("rstmid_no_valid", {63'h0, inst_valid}, 64'h0);
    chk("rstmid_mem_req_after", {63'h0, mem_req}, 64'h0);
    tick;
    chk("rstmid_no_valid2", {63'h0, inst_valid}, 64'h0);
    miss(64'h8000_0008, 1, 64'h0000_00aa_0000_00bb, 1'b0, 32'h0000_00bb);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_valid", {63'h0, inst_valid}, 64'h0);
      chk("idle_mem_req", {63'h0, mem_req}, 64'h0);
      chk("idle_stall", {63'h0, stall_req}, 64'h0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_2022040010_ifetch_resp.md
YSYX_2022040010_IFETCH_RESP -- requirements
Module: ysyx_2022040010_ifetch_resp

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on posedge clk.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: isram_e  input  1  fetch request enable from IF stage.
REQ-004 SHALL have: isram_addr  input  64  fetch byte address, 4-byte aligned.
REQ-005 SHALL have: inst_valid  output  1  inst/inst_err valid this cycle.
REQ-006 SHALL have: inst  output  32  fetched instruction.
REQ-007 SHALL have: inst_err  output  1  memory reported error for this fetch.
REQ-008 SHALL have: stall_req  output  1  hold IF PC; drives IF stall bit 3.
REQ-009 SHALL have: mem_req  output  1  backing-memory read request.
REQ-010 SHALL have: mem_addr  output  64  8-byte-aligned memory address.
REQ-011 SHALL have: mem_ack  input  1  memory read done; mem_rdata/mem_err valid.
REQ-012 SHALL have: mem_rdata  input  64  memory read data, little-endian.
REQ-013 SHALL have: mem_err  input  1  memory read error, qualified by mem_ack.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DONE; encoding free.
REQ-015 Hit SHALL be defined as: line-buffer valid and buf_tag == isram_addr[63:3].
REQ-016 IDLE, isram_e=1, hit: stay IDLE; next cycle inst_valid=1, inst = buffer word half chosen by the latched addr[2] (1 -> bits 63:32), inst_err=0; stall_req=0.
REQ-017 IDLE, isram_e=1, miss: stall_req=1 combinationally in same cycle; latch req_addr=isram_addr; go FETCH.
REQ-018 IDLE, isram_e=0: stay IDLE; inst_valid=0 next cycle.
REQ-019 FETCH: mem_req=1, mem_addr={req_addr[63:3],3'b000}, both held stable until and including the mem_ack cycle; stall_req=1.
REQ-020 FETCH, mem_ack=1, mem_err=0: write mem_rdata into buffer, buf_tag=req_addr[63:3], valid=1; go DONE.
REQ-021 FETCH, mem_ack=1, mem_err=1: buffer unchanged, valid cleared; go DONE with error flag set.
REQ-022 DONE (exactly one cycle): inst_valid=1, stall_req=0, mem_req=0; inst = selected half of captured data, or inst=0 and inst_err=1 on error; go IDLE.
REQ-023 mem_ack SHALL be ignored outside FETCH.
REQ-024 mem_ack arriving in the first FETCH cycle SHALL give minimum miss latency of 2 cycles from request to inst_valid.
REQ-025 inst_valid SHALL never be high for two consecutive cycles for the same request.
REQ-026 isram_e/isram_addr changes while in FETCH SHALL be ignored (IF is stalled).

Reset
REQ-027 rst=1 SHALL force: state IDLE, buffer valid=0, req_addr=0, inst_valid=0, inst=0, inst_err=0, mem_req=0, mem_addr=0, stall_req=0, on the next edge.
REQ-028 rst during FETCH SHALL abandon the transaction; a mem_ack after reset SHALL be discarded.

Configuration
REQ-029 Macro YSYX_2022040010_IFETCH_LINEBUF_EN SHALL control the line buffer.
REQ-030 Defined: REQ-015/016 hit path active.
REQ-031 Undefined: hit is constant 0; every isram_e=1 request takes the FETCH path; buffer registers are not implemented.

Verification
REQ-032 Reset then isram_e=1, addr=0x8000_0000, mem_ack 3 cycles later with rdata=0x0000_0013_0010_0093 -> stall_req high 4 cycles, mem_addr=0x8000_0000, inst_valid with inst=0x0010_0093.
REQ-033 With LINEBUF_EN: next request addr=0x8000_0004 -> no stall, inst_valid next cycle, inst=0x0000_0013, mem_req stays 0.
REQ-034 Request addr=0x8000_0008, mem_ack with mem_err=1 -> inst_valid=1, inst_err=1, inst=0; re-request of 0x8000_000C misses.
REQ-035 rst asserted mid-FETCH, mem_ack one cycle after rst drops -> no inst_valid, mem_req=0, state IDLE.
REQ-036 Without LINEBUF_EN: back-to-back 0x8000_0000/0x8000_0004 -> two mem_req transactions, each stalling.
REQ-037 isram_e=0 for 10 cycles -> inst_valid, mem_req, stall_req all 0 throughout.
